// File: rtl/fifo_wr_full_ctrl.sv
// fifo_wr_full_ctrl
// Write-domain control stage of the asynchronous FIFO. Synchronises the
// read-side Gray pointer into the write clock domain, gates write requests
// into the pointer counter's increment, and produces registered full, fill
// level and overflow flags.
//
// Optional feature macro: FIFO_ALMOST_FULL_EN
//   defined   -> almostFull port and its registered threshold compare exist
//   undefined -> almostFull port and logic are absent
//
// The only combinational output is inc; everything else is a flop output.
// All flops reset asynchronously on rst (active-high). The pointer counter
// shares rst, so after reset both sides restart from pointer 0.

module fifo_wr_full_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int N           = ADDR_W + 1,
    parameter int SYNC_STAGES = 2,
    parameter int AF_TH       = 2**ADDR_W - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wrReq,
    input  logic [N-1:0] wB,
    input  logic [N-1:0] wG,
    input  logic [N-1:0] wGNext,
    input  logic [N-1:0] rGAsync,
    output logic         inc,
    output logic         full,
`ifdef FIFO_ALMOST_FULL_EN
    output logic         almostFull,
`endif
    output logic [N-1:0] level,
    output logic         overflow,
    output logic [N-1:0] rGSync
);

    // Elaboration-time parameter legality checks.
    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("fifo_wr_full_ctrl: ADDR_W must be >= 1");
    end
    if (N != ADDR_W + 1) begin : g_bad_n
        $error("fifo_wr_full_ctrl: N must equal ADDR_W+1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wr_full_ctrl: SYNC_STAGES must be >= 2");
    end
    if (AF_TH < 1 || AF_TH > 2**ADDR_W) begin : g_bad_af_th
        $error("fifo_wr_full_ctrl: AF_TH must be in 1..2**ADDR_W");
    end

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] r_full_cmp;
    logic [N-1:0] r_bin;
    logic [N-1:0] g_eff;
    logic [N-1:0] b_eff;
    logic [N-1:0] level_next;
    logic         full_next;

    // Read-pointer synchroniser: rGAsync lands directly in stage 0 with no
    // logic in front so the first flop only ever sees a single-bit Gray change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= rGAsync;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign rGSync = sync_q[SYNC_STAGES-1];

    // A write is only let through while the registered full flag is clear.
    assign inc = wrReq & ~full;

    // Pointer the counter will hold after this edge, in Gray and binary.
    assign g_eff = inc ? wGNext : wG;
    assign b_eff = wB + N'(inc);

    // Full pattern: the write pointer is one lap ahead of the read pointer,
    // i.e. the read Gray code with its two MSBs inverted.
    if (N == 2) begin : g_full_cmp_n2
        assign r_full_cmp = ~rGSync;
    end else begin : g_full_cmp_wide
        assign r_full_cmp = {~rGSync[N-1:N-2], rGSync[N-3:0]};
    end

    assign full_next = (g_eff == r_full_cmp);

    // Gray-to-binary of the synchronised read pointer: each binary bit is the
    // XOR of all Gray bits at and above it.
    always_comb begin
        r_bin = '0;
        for (int i = 0; i < N; i++) begin
            r_bin[i] = ^(rGSync >> i);
        end
    end

    // Modulo-2^N subtraction stays correct across pointer wrap.
    assign level_next = b_eff - r_bin;

    // Registered status flags; overflow flags a request refused by full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            full     <= full_next;
            level    <= level_next;
            overflow <= wrReq & full;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [N-1:0] AF_TH_N = N'(AF_TH);

    // Almost-full threshold on the same next-level value that feeds level,
    // so it carries the same latency as full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almostFull <= 1'b0;
        end else begin
            almostFull <= (level_next >= AF_TH_N);
        end
    end
`endif

endmodule
